// File: rtl/guvm_feeder_pkg.sv
// Shared constants and state encoding for the instruction feeder.
package guvm_feeder_pkg;

  localparam logic [31:0] NOP_INST = 32'h0100_0000;
  localparam int unsigned DEFAULT_CNT_W = 16;

  typedef logic [1:0] feeder_state_e;

  localparam feeder_state_e S_IDLE   = 2'd0;
  localparam feeder_state_e S_RUN    = 2'd1;
  localparam feeder_state_e S_STARVE = 2'd2;

endpackage

// File: rtl/guvm_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; clear has priority over push and pop.
module guvm_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  assign do_push = !clr_i && push_i && !full_o;
  assign do_pop  = !clr_i && pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: reset empties the FIFO through the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/guvm_inst_feeder.sv
// Instruction source for the LEON icache port: FIFO of pushed words, NOP/stall when dry.
// Optional PC-sequence check enabled by defining INST_FEEDER_ADDR_CHECK_EN.
module guvm_inst_feeder
  import guvm_feeder_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned STALL_ON_EMPTY = 0,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  input  logic [31:0]            in_inst_i,
  output logic                   in_ready_o,
  input  logic                   fetch_req_i,
  input  logic [31:0]            fetch_addr_i,
  output logic [31:0]            ico_data_o,
  output logic                   ico_hold_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   empty_o,
  output logic [CNT_W-1:0]       issued_count_o,
  output logic [CNT_W-1:0]       nop_count_o,
  output logic                   addr_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic          full, empty, push, pop, nop_fetch, hold;
  logic [31:0]   head;
  logic [AW:0]   level;
  feeder_state_e state_q, state_d;
  logic [CNT_W-1:0] issued_q, issued_d, nop_q, nop_d;

  guvm_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_inst_i),
    .rdata_o (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign hold      = !((STALL_ON_EMPTY != 0) && (state_q == S_STARVE));
  assign push      = in_valid_i && !full && !flush_i;
  assign pop       = fetch_req_i && hold && !empty && !flush_i;
  assign nop_fetch = fetch_req_i && hold && empty && !flush_i;

  assign in_ready_o     = !full;
  assign ico_data_o     = empty ? NOP_INST : head;
  assign ico_hold_o     = hold;
  assign level_o        = level;
  assign empty_o        = empty;
  assign issued_count_o = issued_q;
  assign nop_count_o    = nop_q;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_STARVE: if (push) state_d = S_RUN;
        // Last word leaves with nothing arriving behind it.
        S_RUN: if (pop && !push && (level == {{AW{1'b0}}, 1'b1})) state_d = S_STARVE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    issued_d = issued_q;
    nop_d    = nop_q;
    if (pop && (issued_q != '1))      issued_d = issued_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (nop_fetch && (nop_q != '1))   nop_d    = nop_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      issued_q <= '0;
      nop_q    <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      nop_q    <= nop_d;
    end
  end

`ifdef INST_FEEDER_ADDR_CHECK_EN
  logic [31:0] pc_q, pc_d;
  logic        pc_vld_q, pc_vld_d, err_q, err_d;

  always_comb begin
    pc_d     = pc_q;
    pc_vld_d = pc_vld_q;
    err_d    = err_q;
    if (flush_i) begin
      pc_vld_d = 1'b0;
      err_d    = 1'b0;
    end else if (pop) begin
      if (pc_vld_q && (fetch_addr_i != pc_q + 32'd4)) err_d = 1'b1;
      pc_d     = fetch_addr_i;
      pc_vld_d = 1'b1;
    end else if (nop_fetch) begin
      pc_d = fetch_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= '0;
      pc_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pc_vld_q <= pc_vld_d;
      err_q    <= err_d;
    end
  end

  assign addr_err_o = err_q;
`else
  logic unused_fetch_addr;
  assign unused_fetch_addr = ^fetch_addr_i;
  assign addr_err_o        = 1'b0;
`endif

endmodule
